// File: rtl/mem_stage_pkg.sv
// Shared definitions for the pipeline: datapath widths, ALU operation
// encodings used by decode/execute, and small helpers for the memory stage.
package mem_stage_pkg;

    localparam int DATA_W        = 32;
    localparam int REG_W         = 5;
    localparam int DEPTH_DEFAULT = 256;
    localparam int CNT_W         = 16;

    // ALU operation encodings shared with execute and decode
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_NOR  = 4'd11
    } alu_op_t;

    // A memory access is misaligned when it touches a non-word-aligned byte address
    function automatic logic is_misaligned(input logic [1:0] byte_off,
                                           input logic       rd_en,
                                           input logic       wr_en);
        return (rd_en | wr_en) & (byte_off != 2'b00);
    endfunction

    // Register $0 is hard-wired: never a write target nor a forwarding source
    function automatic logic qual_reg_write(input logic             we,
                                            input logic [REG_W-1:0] rd);
        return we & (rd != {REG_W{1'b0}});
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute <-> memory-stage bus: execute results in, EX/DM and DM/WB
// pipeline values (forwarding, squash, write-back) out.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd_in;
    logic              mem_read_in;
    logic              mem_write_in;
    logic              reg_write_in;
    logic              mem_to_reg_in;
    logic              branch_in;

    logic [DATA_W-1:0] result_out_ex_dm;
    logic [REG_W-1:0]  rd_out_ex_dm;
    logic              reg_write_out_ex_dm;
    logic              branch_out_ex_dm;
    logic [DATA_W-1:0] result_out_dm_wb;
    logic [REG_W-1:0]  rd_out_dm_wb;
    logic              reg_write_out_dm_wb;
    logic              misalign_err;
    logic [CNT_W-1:0]  store_count;

    // Execute side / environment
    modport master (
        output alu_result, store_data, rd_in, mem_read_in, mem_write_in,
               reg_write_in, mem_to_reg_in, branch_in,
        input  result_out_ex_dm, rd_out_ex_dm, reg_write_out_ex_dm,
               branch_out_ex_dm, result_out_dm_wb, rd_out_dm_wb,
               reg_write_out_dm_wb, misalign_err, store_count
    );

    // Memory stage
    modport slave (
        input  alu_result, store_data, rd_in, mem_read_in, mem_write_in,
               reg_write_in, mem_to_reg_in, branch_in,
        output result_out_ex_dm, rd_out_ex_dm, reg_write_out_ex_dm,
               branch_out_ex_dm, result_out_dm_wb, rd_out_dm_wb,
               reg_write_out_dm_wb, misalign_err, store_count
    );

endinterface

// File: rtl/mem_stage_data_ram.sv
// Word-wide data RAM: synchronous write, asynchronous read, no reset
// (contents survive a pipeline reset).
module mem_stage_data_ram
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: commit a word on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline: EX/DM register, word loads and
// stores against the data RAM, DM/WB register, plus forwarding/squash
// exports and the sticky misalignment flag / committed-store counter.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    mem_stage_if.slave  bus
);

    // EX/DM pipeline register
    logic [DATA_W-1:0] result_r;
    logic [DATA_W-1:0] store_data_r;
    logic [REG_W-1:0]  rd_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              reg_write_r;
    logic              mem_to_reg_r;
    logic              branch_r;

    // DM/WB pipeline register
    logic [DATA_W-1:0] wb_result_r;
    logic [REG_W-1:0]  wb_rd_r;
    logic              wb_reg_write_r;

    // Status
    logic              misalign_err_r;
    logic [CNT_W-1:0]  store_count_r;

    // Memory-access decode
    logic [AW-1:0]     word_idx_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic              misalign_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] wb_next_s;

    // Upper address bits are ignored so accesses wrap modulo the RAM size
    assign word_idx_s = result_r[AW+1:2];

    // Decide store commit, load data and the write-back value for the
    // instruction currently held in EX/DM
    always_comb begin
        misalign_s  = is_misaligned(result_r[1:0], mem_read_r, mem_write_r);
        ram_we_s    = 1'b0;
        load_data_s = {DATA_W{1'b0}};
        wb_next_s   = result_r;

        // A write is dropped on a misaligned address, while stalled, or in reset
        if (mem_write_r && !misalign_s && !stall && !reset) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end

        // Read+write together behaves as a store, so read data is discarded
        if (mem_read_r && !mem_write_r && !misalign_s) begin
            load_data_s = ram_rdata_s;
        end else begin
            load_data_s = {DATA_W{1'b0}};
        end

        if (mem_to_reg_r) begin
            wb_next_s = load_data_s;
        end else begin
            wb_next_s = result_r;
        end
    end

    mem_stage_data_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (word_idx_s),
        .wdata (store_data_r),
        .raddr (word_idx_s),
        .rdata (ram_rdata_s)
    );

    // EX/DM capture of execute results; holds while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r     <= {DATA_W{1'b0}};
            store_data_r <= {DATA_W{1'b0}};
            rd_r         <= {REG_W{1'b0}};
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            branch_r     <= 1'b0;
        end else if (!stall) begin
            result_r     <= bus.alu_result;
            store_data_r <= bus.store_data;
            rd_r         <= bus.rd_in;
            mem_read_r   <= bus.mem_read_in;
            mem_write_r  <= bus.mem_write_in;
            reg_write_r  <= qual_reg_write(bus.reg_write_in, bus.rd_in);
            mem_to_reg_r <= bus.mem_to_reg_in;
            branch_r     <= bus.branch_in;
        end
    end

    // DM/WB capture of the write-back value; holds while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_result_r    <= {DATA_W{1'b0}};
            wb_rd_r        <= {REG_W{1'b0}};
            wb_reg_write_r <= 1'b0;
        end else if (!stall) begin
            wb_result_r    <= wb_next_s;
            wb_rd_r        <= rd_r;
            wb_reg_write_r <= reg_write_r;
        end
    end

    // Sticky misalignment flag and saturating count of committed stores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err_r <= 1'b0;
            store_count_r  <= {CNT_W{1'b0}};
        end else if (!stall) begin
            if (misalign_s) begin
                misalign_err_r <= 1'b1;
            end
            if (ram_we_s && (store_count_r != {CNT_W{1'b1}})) begin
                store_count_r <= store_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.result_out_ex_dm    = result_r;
    assign bus.rd_out_ex_dm        = rd_r;
    assign bus.reg_write_out_ex_dm = reg_write_r;
    assign bus.branch_out_ex_dm    = branch_r;
    assign bus.result_out_dm_wb    = wb_result_r;
    assign bus.rd_out_dm_wb        = wb_rd_r;
    assign bus.reg_write_out_dm_wb = wb_reg_write_r;
    assign bus.misalign_err        = misalign_err_r;
    assign bus.store_count         = store_count_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage plus hand-written sequences
// for stall and asynchronous reset.
module tb_mem_stage;

    logic clk;
    logic reset;
    logic stall;

    mem_stage_if bus ();

    mem_stage #(.DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
        logic        br;
        logic        ex_rw;
        logic        ex_br;
        logic [31:0] wb_res;
        logic        wb_rw;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic br);
        bus.alu_result    = alu;
        bus.store_data    = sd;
        bus.rd_in         = rd;
        bus.mem_read_in   = mr;
        bus.mem_write_in  = mw;
        bus.reg_write_in  = rw;
        bus.mem_to_reg_in = m2r;
        bus.branch_in     = br;
    endtask

    task automatic bubble();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_res"}, bus.result_out_ex_dm, 32'h0);
        check({tag, "_ex_rd"},  {27'h0, bus.rd_out_ex_dm}, 32'h0);
        check({tag, "_ex_rw"},  {31'h0, bus.reg_write_out_ex_dm}, 32'h0);
        check({tag, "_ex_br"},  {31'h0, bus.branch_out_ex_dm}, 32'h0);
        check({tag, "_wb_res"}, bus.result_out_dm_wb, 32'h0);
        check({tag, "_wb_rd"},  {27'h0, bus.rd_out_dm_wb}, 32'h0);
        check({tag, "_wb_rw"},  {31'h0, bus.reg_write_out_dm_wb}, 32'h0);
        check({tag, "_err"},    {31'h0, bus.misalign_err}, 32'h0);
        check({tag, "_cnt"},    {16'h0, bus.store_count}, 32'h0);
    endtask

    task automatic check_wb(input int i);
        check($sformatf("v%0d_wb_res", i), bus.result_out_dm_wb, vecs[i].wb_res);
        check($sformatf("v%0d_wb_rd", i),  {27'h0, bus.rd_out_dm_wb}, {27'h0, vecs[i].rd});
        check($sformatf("v%0d_wb_rw", i),  {31'h0, bus.reg_write_out_dm_wb}, {31'h0, vecs[i].wb_rw});
        check($sformatf("v%0d_cnt", i),    {16'h0, bus.store_count}, {16'h0, vecs[i].cnt});
        check($sformatf("v%0d_err", i),    {31'h0, bus.misalign_err}, {31'h0, vecs[i].err});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        // alu, sd, rd, mr, mw, rw, m2r, br | ex_rw, ex_br, wb_res, wb_rw, cnt, err
        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'h0000_0010, 1'b0, 16'd1, 1'b0};
        vecs[1]  = '{32'h0000_0010, 32'h0,         5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 16'd1, 1'b0};
        vecs[2]  = '{32'h0000_0055, 32'h0,         5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'h0000_0055, 1'b0, 16'd1, 1'b0};
        vecs[3]  = '{32'hCAFE_0001, 32'h0,         5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                     1'b1, 1'b1, 32'hCAFE_0001, 1'b1, 16'd1, 1'b0};
        vecs[4]  = '{32'h0000_0400, 32'h0000_1234, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'h0000_0400, 1'b0, 16'd2, 1'b0};
        vecs[5]  = '{32'h0000_0000, 32'h0,         5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b0, 32'h0000_1234, 1'b1, 16'd2, 1'b0};
        vecs[6]  = '{32'h0000_0013, 32'hFFFF_FFFF, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'h0000_0013, 1'b0, 16'd2, 1'b1};
        vecs[7]  = '{32'h0000_0010, 32'h0,         5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 16'd2, 1'b1};
        vecs[8]  = '{32'h0000_0013, 32'h0,         5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b0, 32'h0000_0000, 1'b1, 16'd2, 1'b1};
        vecs[9]  = '{32'h0000_0020, 32'h0000_0077, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b1, 1'b0, 32'h0000_0020, 1'b1, 16'd3, 1'b1};
        vecs[10] = '{32'h0000_0020, 32'h0,         5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b0, 32'h0000_0077, 1'b1, 16'd3, 1'b1};

        reset = 1'b1;
        stall = 1'b0;
        bubble();
        step();
        step();
        check_all_zero("rst");
        reset = 1'b0;

        // Table: check EX/DM of vector i, and DM/WB/status of vector i-1
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].alu, vecs[i].sd, vecs[i].rd, vecs[i].mr, vecs[i].mw,
                  vecs[i].rw, vecs[i].m2r, vecs[i].br);
            step();
            check($sformatf("v%0d_ex_res", i), bus.result_out_ex_dm, vecs[i].alu);
            check($sformatf("v%0d_ex_rd", i),  {27'h0, bus.rd_out_ex_dm}, {27'h0, vecs[i].rd});
            check($sformatf("v%0d_ex_rw", i),  {31'h0, bus.reg_write_out_ex_dm}, {31'h0, vecs[i].ex_rw});
            check($sformatf("v%0d_ex_br", i),  {31'h0, bus.branch_out_ex_dm}, {31'h0, vecs[i].ex_br});
            if (i > 0) begin
                check_wb(i - 1);
            end
        end
        bubble();
        step();
        check_wb(NV - 1);

        // Stall while a store sits in EX/DM
        drive(32'h0000_0030, 32'h1111_1111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(32'h0000_0030, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("pre_stall_cnt", {16'h0, bus.store_count}, 32'd4);
        stall = 1'b1;
        drive(32'h0000_0099, 32'h0BAD_0BAD, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d_ex_res", k), bus.result_out_ex_dm, 32'h0000_0030);
            check($sformatf("stall%0d_ex_br", k),  {31'h0, bus.branch_out_ex_dm}, 32'h0);
            check($sformatf("stall%0d_wb_res", k), bus.result_out_dm_wb, 32'h0000_0030);
            check($sformatf("stall%0d_cnt", k),    {16'h0, bus.store_count}, 32'd4);
        end
        stall = 1'b0;
        drive(32'h0000_0030, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check("unstall_cnt", {16'h0, bus.store_count}, 32'd5);
        bubble();
        step();
        check("unstall_load", bus.result_out_dm_wb, 32'hA5A5_A5A5);
        check("unstall_rd",   {27'h0, bus.rd_out_dm_wb}, 32'd13);
        check("unstall_cnt2", {16'h0, bus.store_count}, 32'd5);

        // Asynchronous reset in the middle of a store
        drive(32'h0000_0030, 32'hBBBB_BBBB, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("midrst_ex_res", bus.result_out_ex_dm, 32'h0000_0030);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        bubble();
        step();
        reset = 1'b0;
        drive(32'h0000_0030, 32'h0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        bubble();
        step();
        check("postrst_load", bus.result_out_dm_wb, 32'hA5A5_A5A5);
        check("postrst_cnt",  {16'h0, bus.store_count}, 32'd0);
        check("postrst_err",  {31'h0, bus.misalign_err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
